// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: base opcodes reused by the decoder and the
// hazard scoreboard, plus the register-usage record of one instruction.
package rv32i_pkg;

   localparam logic [6:0] OP_ALU     = 7'b0110011;
   localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_BRANCH  = 7'b1100011;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_JALR    = 7'b1100111;
   localparam logic [6:0] OP_LUI     = 7'b0110111;
   localparam logic [6:0] OP_AUIPC   = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

   // Which architectural operands an opcode reads and whether it writes rd.
   typedef struct packed {
      logic uses_rs1;
      logic uses_rs2;
      logic writes_rd;
   } reg_use_t;

endpackage

// File: rtl/reg_use_classifier.sv
// Opcode -> register usage. Purely combinational; writes_rd here is the
// opcode class only, the rd != x0 qualification is applied by the caller.
module reg_use_classifier
   import rv32i_pkg::*;
(
   input  logic [6:0] opcode,
   output logic       uses_rs1,
   output logic       uses_rs2,
   output logic       writes_rd
);

   reg_use_t use_s;

   // Decode the opcode into its operand usage; unknown and SYSTEM use nothing.
   always_comb begin
      use_s = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b0};
      case (opcode)
         OP_ALU:     use_s = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b1};
         OP_ALU_IMM: use_s = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1};
         OP_LOAD:    use_s = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1};
         OP_JALR:    use_s = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1};
         OP_STORE:   use_s = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0};
         OP_BRANCH:  use_s = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0};
         OP_LUI:     use_s = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1};
         OP_AUIPC:   use_s = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1};
         OP_JAL:     use_s = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1};
         OP_SYSTEM:  use_s = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b0};
         default:    use_s = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b0};
      endcase
   end

   assign uses_rs1  = use_s.uses_rs1;
   assign uses_rs2  = use_s.uses_rs2;
   assign writes_rd = use_s.writes_rd;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard and issue controller between decode and execute.
// Tracks in-flight register writes, stalls decode on RAW/WAW hazards or when
// the in-flight limit is reached, and clears busy bits on writeback. A register
// retiring this cycle is bypassed so it never causes a hazard.
module hazard_scoreboard
   import rv32i_pkg::*;
#(
   parameter int ADDRW        = 5,
   parameter int MAX_INFLIGHT = 4,
   parameter int CNTW         = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [6:0]            id_opcode,
   input  logic [ADDRW-1:0]      id_rs1,
   input  logic [ADDRW-1:0]      id_rs2,
   input  logic [ADDRW-1:0]      id_rd,
   input  logic                  ex_ready,
   input  logic                  wb_valid,
   input  logic [ADDRW-1:0]      wb_rd,
   input  logic                  flush,
   output logic                  issue_valid,
   output logic                  id_stall,
   output logic [2**ADDRW-1:0]   pending,
   output logic [CNTW-1:0]       inflight_cnt
);

   localparam int NREGS = 2**ADDRW;
   localparam logic [NREGS-1:0] BIT0     = {{(NREGS-1){1'b0}}, 1'b1};
   localparam logic [CNTW-1:0]  CNT_FULL = CNTW'(MAX_INFLIGHT);

   logic             uses_rs1_s;
   logic             uses_rs2_s;
   logic             writes_cls_s;
   logic             writes_rd_s;
   logic [NREGS-1:0] wb_onehot_s;
   logic [NREGS-1:0] eff_pending_s;
   logic             wb_dec_s;
   logic [CNTW-1:0]  cnt_after_wb_s;
   logic             full_s;
   logic             hazard_s;
   logic             issue_s;
   logic             stall_s;
   logic [NREGS-1:0] pending_nxt_s;
   logic [CNTW-1:0]  cnt_nxt_s;
   logic [NREGS-1:0] pending_r;
   logic [CNTW-1:0]  cnt_r;

   reg_use_classifier u_classifier (
      .opcode    (id_opcode),
      .uses_rs1  (uses_rs1_s),
      .uses_rs2  (uses_rs2_s),
      .writes_rd (writes_cls_s)
   );

   // Hazard, limit and issue decisions for the instruction sitting in decode.
   always_comb begin
      wb_onehot_s    = '0;
      if (wb_valid) begin
         wb_onehot_s = BIT0 << wb_rd;
      end else begin
         wb_onehot_s = '0;
      end
      eff_pending_s  = pending_r & ~wb_onehot_s;
      // Only a writeback that actually retires a busy register frees a slot;
      // stale writebacks (after flush, or to x0) are ignored.
      wb_dec_s       = wb_valid & pending_r[wb_rd];
      cnt_after_wb_s = cnt_r - {{(CNTW-1){1'b0}}, wb_dec_s};
      full_s         = (cnt_after_wb_s == CNT_FULL);
      writes_rd_s    = writes_cls_s & (id_rd != {ADDRW{1'b0}});
      hazard_s       = (uses_rs1_s & (id_rs1 != {ADDRW{1'b0}}) & eff_pending_s[id_rs1])
                     | (uses_rs2_s & (id_rs2 != {ADDRW{1'b0}}) & eff_pending_s[id_rs2])
                     | (writes_rd_s & eff_pending_s[id_rd]);
      issue_s        = id_valid & ex_ready & ~flush & ~hazard_s & ~(writes_rd_s & full_s);
      stall_s        = id_valid & ~issue_s & ~flush;
   end

   // Next scoreboard state: flush drops everything, otherwise retire then set.
   always_comb begin
      pending_nxt_s = pending_r;
      cnt_nxt_s     = cnt_r;
      if (flush) begin
         pending_nxt_s = '0;
         cnt_nxt_s     = '0;
      end else if (issue_s && writes_rd_s) begin
         // Set wins over a same-cycle writeback of the same rd.
         pending_nxt_s = eff_pending_s | (BIT0 << id_rd);
         cnt_nxt_s     = cnt_after_wb_s + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
         pending_nxt_s = eff_pending_s;
         cnt_nxt_s     = cnt_after_wb_s;
      end
   end

   // Scoreboard bitmap and in-flight counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_r <= '0;
         cnt_r     <= '0;
      end else begin
         pending_r <= pending_nxt_s;
         cnt_r     <= cnt_nxt_s;
      end
   end

   assign issue_valid  = issue_s;
   assign id_stall     = stall_s;
   assign pending      = pending_r;
   assign inflight_cnt = cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by
// random traffic, all checked against a set-of-busy-registers model.
module tb_hazard_scoreboard;

   localparam int ADDRW = 5;
   localparam int MAXI  = 4;
   localparam int NREGS = 32;
   localparam int CNTW  = 3;

   localparam logic [6:0] ALU = 7'b0110011, ALUI = 7'b0010011, LOAD = 7'b0000011,
                          STORE = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111,
                          JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111,
                          SYS = 7'b1110011, UNK = 7'b1111111;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             id_valid, ex_ready, wb_valid, flush;
   logic [6:0]       id_opcode;
   logic [ADDRW-1:0] id_rs1, id_rs2, id_rd, wb_rd;
   logic             issue_valid, id_stall;
   logic [NREGS-1:0] pending;
   logic [CNTW-1:0]  inflight_cnt;

   int n_vec = 0;
   int n_err = 0;
   bit busy[NREGS];

   always #5 clk = ~clk;

   hazard_scoreboard #(.ADDRW(ADDRW), .MAX_INFLIGHT(MAXI)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_ready(ex_ready),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
      .issue_valid(issue_valid), .id_stall(id_stall),
      .pending(pending), .inflight_cnt(inflight_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic void classify(input logic [6:0] op, output bit r1, output bit r2, output bit w);
      r1 = 1'b0; r2 = 1'b0; w = 1'b0;
      case (op)
         ALU:               begin r1 = 1'b1; r2 = 1'b1; w = 1'b1; end
         ALUI, LOAD, JALR:  begin r1 = 1'b1; w = 1'b1; end
         STORE, BR:         begin r1 = 1'b1; r2 = 1'b1; end
         LUI, AUIPC, JAL:   w = 1'b1;
         default:           ;
      endcase
   endfunction

   function automatic logic [31:0] busy_vec();
      logic [31:0] v = 32'h0;
      for (int i = 0; i < NREGS; i++) v[i] = busy[i];
      return v;
   endfunction

   function automatic int busy_count();
      int c = 0;
      for (int i = 0; i < NREGS; i++) c += int'(busy[i]);
      return c;
   endfunction

   function automatic void clear_model();
      for (int i = 0; i < NREGS; i++) busy[i] = 1'b0;
   endfunction

   // One cycle: drive, check combinational outputs, advance model, check state.
   task automatic apply(input bit v, input logic [6:0] op, input int rs1, input int rs2,
                        input int rd, input bit exr, input bit wbv, input int wbrd, input bit fl);
      bit r1, r2, w, hz, full, exp_issue, exp_stall, wbdec;
      bit eff[NREGS];
      @(negedge clk);
      id_valid = v; id_opcode = op; id_rs1 = rs1[4:0]; id_rs2 = rs2[4:0]; id_rd = rd[4:0];
      ex_ready = exr; wb_valid = wbv; wb_rd = wbrd[4:0]; flush = fl;
      #1;
      classify(op, r1, r2, w);
      w     = w && (rd != 0);
      eff   = busy;
      if (wbv) eff[wbrd] = 1'b0;
      wbdec = wbv && busy[wbrd];
      hz    = (r1 && rs1 != 0 && eff[rs1]) || (r2 && rs2 != 0 && eff[rs2]) || (w && eff[rd]);
      full  = (busy_count() - int'(wbdec)) == MAXI;
      exp_issue = v && exr && !fl && !hz && !(w && full);
      exp_stall = v && !exp_issue && !fl;
      check("issue_valid", 32'(issue_valid), 32'(exp_issue));
      check("id_stall", 32'(id_stall), 32'(exp_stall));
      if (fl) begin
         clear_model();
      end else begin
         busy = eff;
         if (exp_issue && w) busy[rd] = 1'b1;
      end
      @(posedge clk);
      #1;
      check("pending", pending, busy_vec());
      check("inflight_cnt", 32'(inflight_cnt), busy_count());
   endtask

   task automatic idle();
      apply(1'b0, UNK, 0, 0, 0, 1'b1, 1'b0, 0, 1'b0);
   endtask

   logic [6:0] ops[11] = '{ALU, ALUI, LOAD, STORE, BR, JAL, JALR, LUI, AUIPC, SYS, UNK};

   initial begin
      rst_n = 1'b0; id_valid = 1'b0; id_opcode = 7'h0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
      ex_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      check("rst_pending", pending, 32'h0);
      check("rst_cnt", 32'(inflight_cnt), 32'd0);
      check("rst_issue", 32'(issue_valid), 32'd0);
      check("rst_stall", 32'(id_stall), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Load into x5 issues and marks x5 busy.
      apply(1'b1, LOAD, 0, 0, 5, 1'b1, 1'b0, 0, 1'b0);
      check("t1_pending", pending, 32'h0000_0020);
      // RAW on x5 stalls, then issues with the x5 writeback bypass.
      apply(1'b1, ALU, 5, 1, 6, 1'b1, 1'b0, 0, 1'b0);
      apply(1'b1, ALU, 5, 1, 6, 1'b1, 1'b1, 5, 1'b0);
      check("t2_pending", pending, 32'h0000_0040);
      // WAW with same-cycle writeback of rd: set wins, count unchanged.
      apply(1'b1, LUI, 0, 0, 6, 1'b1, 1'b1, 6, 1'b0);
      check("t3_pending", pending, 32'h0000_0040);
      check("t3_cnt", 32'(inflight_cnt), 32'd1);
      apply(1'b0, UNK, 0, 0, 0, 1'b1, 1'b1, 6, 1'b0);
      // Fill the in-flight limit, then a writer stalls while a store issues.
      for (int r = 1; r <= 4; r++) apply(1'b1, LUI, 0, 0, r, 1'b1, 1'b0, 0, 1'b0);
      apply(1'b1, LUI, 0, 0, 7, 1'b1, 1'b0, 0, 1'b0);
      apply(1'b1, STORE, 0, 0, 9, 1'b1, 1'b0, 0, 1'b0);
      apply(1'b1, LUI, 0, 0, 7, 1'b1, 1'b1, 1, 1'b0);
      check("t4_pending", pending, 32'h0000_009C);
      check("t4_cnt", 32'(inflight_cnt), 32'd4);
      // x0 destination / non-writers, and writebacks to x0 or idle registers.
      apply(1'b1, ALUI, 0, 0, 0, 1'b1, 1'b0, 0, 1'b0);
      apply(1'b1, BR, 0, 0, 0, 1'b1, 1'b0, 0, 1'b0);
      apply(1'b0, UNK, 0, 0, 0, 1'b1, 1'b1, 0, 1'b0);
      apply(1'b0, UNK, 0, 0, 0, 1'b1, 1'b1, 9, 1'b0);
      check("t5_cnt", 32'(inflight_cnt), 32'd4);
      // Flush, rebuild {1,2,3}, flush again, stale writeback ignored.
      apply(1'b1, LUI, 0, 0, 8, 1'b1, 1'b0, 0, 1'b1);
      for (int r = 1; r <= 3; r++) apply(1'b1, LUI, 0, 0, r, 1'b1, 1'b0, 0, 1'b0);
      apply(1'b0, UNK, 0, 0, 0, 1'b1, 1'b0, 0, 1'b1);
      apply(1'b0, UNK, 0, 0, 0, 1'b1, 1'b1, 2, 1'b0);
      check("t6_pending", pending, 32'h0);
      check("t6_cnt", 32'(inflight_cnt), 32'd0);
      // Asynchronous reset in the middle of a RAW stall.
      apply(1'b1, LOAD, 0, 0, 5, 1'b1, 1'b0, 0, 1'b0);
      apply(1'b1, ALU, 5, 0, 6, 1'b1, 1'b0, 0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_pending", pending, 32'h0);
      check("arst_cnt", 32'(inflight_cnt), 32'd0);
      id_valid = 1'b0;
      #1;
      check("arst_issue", 32'(issue_valid), 32'd0);
      check("arst_stall", 32'(id_stall), 32'd0);
      clear_model();
      @(negedge clk);
      rst_n = 1'b1;
      apply(1'b1, ALU, 5, 0, 6, 1'b1, 1'b0, 0, 1'b0);

      // Random traffic on a small register window to provoke hazards.
      for (int n = 0; n < 400; n++) begin
         apply($urandom_range(0, 9) != 0, ops[$urandom_range(0, 10)],
               $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 7), $urandom_range(0, 40) == 0);
      end
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
